// File: rtl/jk_sched_pkg.sv
// jk_sched_pkg: shared command and FSM types for the JK bank scheduler.
package jk_sched_pkg;
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_t;
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: one JK flip-flop of the bank, updated only when enabled.
module jk_cell
    import jk_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);
    jk_cmd_t c;
    assign c = jk_cmd_t'({j_i, k_i});
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_o <= 1'b0;
        else if (en_i) q_o <= c == JK_TGL ? ~q_o : c == JK_SET ? 1'b1 : c == JK_RST ? 1'b0 : q_o;
    end
endmodule

// File: rtl/jk_bank_scheduler.sv
// jk_bank_scheduler: round-robin sharing of a JK cell bank among requesters.
// Define JK_SCHED_LOCK_EN to let a granted requester lock the bank to itself.
module jk_bank_scheduler
    import jk_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [2*NREQ-1:0]    cmd_i,
    input  logic [IDXW*NREQ-1:0] idx_i,
    input  logic [NREQ-1:0]      lock_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NBITS-1:0]     q_o,
    output logic                 err_o,
    output logic                 busy_o
);
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0]   ptr_q, ptr_d, arb_win, sel, nxt;
    logic            arb_hit, hit, adv, bad, err_q;
    logic [1:0]      cmd_sel;
    logic [IDXW-1:0] idx_sel;
    // Scan downward so the lowest offset from the pointer is the last writer.
    always_comb begin
        arb_win = '0;
        arb_hit = 1'b0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            if (req_i[(int'(ptr_q) + o) % NREQ]) begin
                arb_hit = 1'b1;
                arb_win = PW'((int'(ptr_q) + o) % NREQ);
            end
        end
    end
`ifdef JK_SCHED_LOCK_EN
    state_t        state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic          locked;
    assign locked = state_q == ST_LOCK;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ARB;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (!locked) begin
            if (hit && lock_i[sel]) begin
                state_d = ST_LOCK;
                owner_d = sel;
            end
        end else if (!lock_i[owner_q]) begin
            state_d = ST_ARB;
        end
    end
    assign sel = locked ? owner_q : arb_win;
    assign hit = locked ? req_i[owner_q] : arb_hit;
    assign adv = locked ? !lock_i[owner_q] : hit;
`else
    logic unused_lock;
    assign unused_lock = ^lock_i;
    assign sel = arb_win;
    assign hit = arb_hit;
    assign adv = hit;
`endif
    assign nxt     = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
    assign ptr_d   = adv ? nxt : ptr_q;
    assign gnt_o   = hit ? {{(NREQ-1){1'b0}}, 1'b1} << sel : '0;
    assign cmd_sel = cmd_i[2*sel +: 2];
    assign idx_sel = idx_i[IDXW*sel +: IDXW];
    assign bad     = hit && (int'(idx_sel) >= NBITS);
    assign err_o   = err_q;
    assign busy_o  = |req_i;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= bad;
        end
    end
    for (genvar g = 0; g < NBITS; g++) begin : g_cell
        jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .en_i (hit && idx_sel == IDXW'(g)),
            .j_i  (cmd_sel[1]),
            .k_i  (cmd_sel[0]),
            .q_o  (q_o[g])
        );
    end
endmodule
